// File: rtl/wb_stage_if.sv
// Writeback-stage bus: memory-stage result in, register-file write port and status out.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif

interface wb_stage_if #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                     wb_i_ce;
  logic                     wb_i_flush;
  logic                     wb_i_stall;
  logic [`OPCODE_WIDTH-1:0] wb_i_opcode;
  logic [AWIDTH-1:0]        wb_i_rd_addr;
  logic [DWIDTH-1:0]        wb_i_rd_data;
  logic                     wb_i_rd_we;
  logic [DWIDTH-1:0]        wb_i_load_data;
  logic [AWIDTH-1:0]        wb_o_rd_addr;
  logic [DWIDTH-1:0]        wb_o_rd_data;
  logic                     wb_o_rd_we;
  logic                     wb_o_ce;
  logic                     wb_o_stall;
  logic                     wb_o_flush;
  logic                     wb_o_overflow;
  logic [CNT_WIDTH-1:0]     wb_o_retired;

  modport master (
    output wb_i_ce, wb_i_flush, wb_i_stall, wb_i_opcode, wb_i_rd_addr,
           wb_i_rd_data, wb_i_rd_we, wb_i_load_data,
    input  wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_ce, wb_o_stall,
           wb_o_flush, wb_o_overflow, wb_o_retired
  );

  modport slave (
    input  wb_i_ce, wb_i_flush, wb_i_stall, wb_i_opcode, wb_i_rd_addr,
           wb_i_rd_data, wb_i_rd_we, wb_i_load_data,
    output wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_ce, wb_o_stall,
           wb_o_flush, wb_o_overflow, wb_o_retired
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects the retiring value, drives the register-file write port,
// and absorbs the memory stage's one-cycle-late stall with a one-entry skid buffer.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif

module wb_stage #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  wb_stage_if.slave  wb
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nxt;
  logic [AWIDTH-1:0]    buf_addr, buf_addr_nxt;
  logic [DWIDTH-1:0]    buf_data, buf_data_nxt;
  logic                 buf_we, buf_we_nxt;
  logic [AWIDTH-1:0]    rd_addr_q, rd_addr_nxt;
  logic [DWIDTH-1:0]    rd_data_q, rd_data_nxt;
  logic                 rd_we_q, rd_we_nxt;
  logic                 ce_q, ce_nxt;
  logic                 stall_q, stall_nxt;
  logic                 flush_q, flush_nxt;
  logic                 ovf_q, ovf_nxt;
  logic [CNT_WIDTH-1:0] retired_q, retired_nxt;

  logic                 in_valid;
  logic                 in_we;
  logic [DWIDTH-1:0]    in_data;

  // Incoming entry: value selection and write-enable qualification (x0 never written)
  always_comb begin
    in_valid = wb.wb_i_ce & ~wb.wb_i_flush;
    in_data  = wb.wb_i_rd_data;
    in_we    = wb.wb_i_rd_we;
    if (wb.wb_i_opcode == `LOAD_WORD) begin
      in_data = wb.wb_i_load_data;
      in_we   = 1'b1;
    end else if (wb.wb_i_opcode == `STORE_WORD) begin
      in_we = 1'b0;
    end
    if (wb.wb_i_rd_addr == '0) in_we = 1'b0;
  end

  // Next state and next registered outputs; buffered entry always retires first
  always_comb begin
    state_nxt    = state;
    buf_addr_nxt = buf_addr;
    buf_data_nxt = buf_data;
    buf_we_nxt   = buf_we;
    rd_addr_nxt  = rd_addr_q;
    rd_data_nxt  = rd_data_q;
    rd_we_nxt    = 1'b0;
    ce_nxt       = 1'b0;
    flush_nxt    = wb.wb_i_flush;
    ovf_nxt      = ovf_q;

    if (wb.wb_i_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (!wb.wb_i_stall) begin
            if (in_valid) begin
              rd_addr_nxt = wb.wb_i_rd_addr;
              rd_data_nxt = in_data;
              rd_we_nxt   = in_we;
              ce_nxt      = 1'b1;
            end
          end else if (in_valid) begin
            buf_addr_nxt = wb.wb_i_rd_addr;
            buf_data_nxt = in_data;
            buf_we_nxt   = in_we;
            state_nxt    = FULL;
          end
        end
        FULL: begin
          if (!wb.wb_i_stall) begin
            rd_addr_nxt = buf_addr;
            rd_data_nxt = buf_data;
            rd_we_nxt   = buf_we;
            ce_nxt      = 1'b1;
            if (in_valid) begin
              buf_addr_nxt = wb.wb_i_rd_addr;
              buf_data_nxt = in_data;
              buf_we_nxt   = in_we;
            end else begin
              state_nxt = EMPTY;
            end
          end else if (in_valid) begin
            ovf_nxt = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end

    stall_nxt   = (state_nxt == FULL);
    retired_nxt = retired_q + CNT_WIDTH'(ce_nxt);
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= EMPTY;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_we    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      ce_q      <= 1'b0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      ovf_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state     <= state_nxt;
      buf_addr  <= buf_addr_nxt;
      buf_data  <= buf_data_nxt;
      buf_we    <= buf_we_nxt;
      rd_addr_q <= rd_addr_nxt;
      rd_data_q <= rd_data_nxt;
      rd_we_q   <= rd_we_nxt;
      ce_q      <= ce_nxt;
      stall_q   <= stall_nxt;
      flush_q   <= flush_nxt;
      ovf_q     <= ovf_nxt;
      retired_q <= retired_nxt;
    end
  end

  assign wb.wb_o_rd_addr  = rd_addr_q;
  assign wb.wb_o_rd_data  = rd_data_q;
  assign wb.wb_o_rd_we    = rd_we_q;
  assign wb.wb_o_ce       = ce_q;
  assign wb.wb_o_stall    = stall_q;
  assign wb.wb_o_flush    = flush_q;
  assign wb.wb_o_overflow = ovf_q;
  assign wb.wb_o_retired  = retired_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory stage.
- Consumes the memory stage's committed result (opcode, rd address/data/write-enable, load data) and selects the value to retire.
- Drives the register-file write port and reports retirement.
- Contains a one-entry skid buffer so the memory stage's registered stall (one cycle late) never loses an instruction while the register-file port is blocked.

Parameters:
DWIDTH, 32, data/register width
AWIDTH, 5, register address width
CNT_WIDTH, 32, retired-instruction counter width

Ports:
wb_clk  input  1  clock, rising edge
wb_rst  input  1  asynchronous active-low reset
wb_i_ce  input  1  incoming instruction valid (from memory stage me_o_ce)
wb_i_flush  input  1  discard buffered and incoming instructions
wb_i_stall  input  1  register-file write port blocked this cycle
wb_i_opcode  input  `OPCODE_WIDTH  opcode of incoming instruction
wb_i_rd_addr  input  AWIDTH  destination register
wb_i_rd_data  input  DWIDTH  ALU/jump result
wb_i_rd_we  input  1  write request for non-load instructions
wb_i_load_data  input  DWIDTH  aligned, extended load result
wb_o_rd_addr  output  AWIDTH  register-file write address
wb_o_rd_data  output  DWIDTH  register-file write data
wb_o_rd_we  output  1  register-file write enable, one-cycle pulse
wb_o_ce  output  1  an instruction retired this cycle
wb_o_stall  output  1  skid buffer occupied; upstream must hold
wb_o_flush  output  1  registered copy of wb_i_flush
wb_o_overflow  output  1  sticky protocol-error flag
wb_o_retired  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (wb_rst=0, async): all outputs 0; skid buffer empty (state EMPTY).
- Entry formation, combinational:
  - Valid = wb_i_ce & !wb_i_flush.
  - Data = wb_i_load_data if wb_i_opcode==`LOAD_WORD, else wb_i_rd_data.
  - We = 1 for `LOAD_WORD, 0 for `STORE_WORD, otherwise wb_i_rd_we.
  - We is forced to 0 when rd_addr==0.
- All outputs are registered. The latency from an accepted entry to wb_o_rd_we/wb_o_ce is 1 cycle when unstalled.
- State EMPTY:
  - wb_i_stall=0: commit the incoming entry to the outputs. wb_o_ce=valid, wb_o_rd_we=valid&we. Stay EMPTY.
  - wb_i_stall=1: wb_o_rd_we=0 and wb_o_ce=0. If the entry is valid, capture it into the buffer and go to FULL.
- State FULL:
  - wb_i_stall=0: commit the buffered entry. If an incoming entry is valid, it replaces the buffer contents and the state stays FULL. Otherwise go to EMPTY.
  - wb_i_stall=1: hold. If an incoming entry is valid, it is dropped and wb_o_overflow is set. The flag is sticky until reset.
- wb_o_stall is registered and equals 1 when the next state is FULL.
- Commit order is strict: the buffered entry always retires before a newer incoming entry.
- Non-commit cycles: wb_o_rd_we=0 and wb_o_ce=0. wb_o_rd_addr and wb_o_rd_data hold their last values.
- wb_i_flush=1:
  - Empties the buffer and goes to EMPTY.
  - No commit that cycle.
  - wb_o_flush=1 next cycle, and wb_o_stall=0 next cycle.
  - Flush has priority over stall and over incoming valid.
- wb_o_retired increments by 1 on every cycle where wb_o_ce is set (stores and x0 writes included). It wraps modulo 2^CNT_WIDTH. Flushed or dropped entries do not count.

Test Plan:
- RTYPE entry (rd=5, rd_data=0x1234, rd_we=1, ce=1) with no stall -> next cycle wb_o_rd_we=1, addr=5, data=0x1234, wb_o_ce=1, wb_o_retired=1.
- LOAD_WORD entry (rd=7, load_data=0xFFFFFF80, rd_data=0x40, rd_we=0) -> wb_o_rd_data=0xFFFFFF80, wb_o_rd_we=1. STORE_WORD entry -> wb_o_ce=1, wb_o_rd_we=0.
- Write with rd=0 and data 0xDEAD -> wb_o_rd_we=0, wb_o_ce=1, counter increments.
- Entry A with wb_i_stall=1 for 3 cycles:
  - wb_o_stall=1 from the next cycle.
  - Entry B arrives in the cycle stall deasserts -> A retires that edge and B retires the following edge.
  - wb_o_overflow stays 0.
- FULL with stall held and a new valid entry -> wb_o_overflow=1 and stays 1 after the stall clears. Only the buffered entry retires.
- Buffer FULL, assert wb_i_flush with stall=1 -> next cycle wb_o_flush=1, wb_o_stall=0, no write. Then assert wb_rst=0 mid-stream -> all outputs 0 asynchronously.
